// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and BCD limits for the irrigation timer
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] SEC_UNITS_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX  = 4'd5;
  localparam logic [DIGIT_W-1:0] MIN_UNITS_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] MIN_TENS_MAX  = 4'd9;

  // A preset is loadable only as well-formed, non-zero MM:SS BCD.
  function automatic logic preset_valid(input logic [15:0] p);
    return (p[15:12] <= MIN_TENS_MAX) && (p[11:8] <= MIN_UNITS_MAX) &&
           (p[7:4] <= SEC_TENS_MAX) && (p[3:0] <= SEC_UNITS_MAX) &&
           (p != 16'h0000);
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// rtl/bcd_digit_down.sv - one loadable BCD down-counting digit with borrow out
module bcd_digit_down
  import timer_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = 4'd9
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_value,
  input  logic               enable,
  input  logic               borrow_in,
  output logic [DIGIT_W-1:0] value,
  output logic               borrow_out
);

  logic dec;

  assign dec        = enable & borrow_in;
  assign borrow_out = dec & (value == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (dec) begin
      value <= (value == '0) ? MAX : value - 4'd1;
    end
  end

endmodule

// File: rtl/irrigation_timer_sequencer.sv
// rtl/irrigation_timer_sequencer.sv - MM:SS countdown with prescaler and control FSM
module irrigation_timer_sequencer
  import timer_pkg::*;
#(
  parameter int PRESCALE = 50_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        stop,
  input  logic [15:0] preset,
  output logic [15:0] digits,
  output logic        running,
  output logic        paused,
  output logic        valve_on,
  output logic        done,
  output logic        load_error
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  state_t        state, state_next;
  logic [PW-1:0] presc, presc_next;
  logic          load_error_next;
  logic          tick;
  logic          load;
  logic [15:0]   load_value;
  logic          su_borrow, st_borrow, mu_borrow, mt_borrow;

  // A tick only happens when nothing of higher priority is asserted.
  assign tick = (state == RUNNING) && !stop && !pause && (presc == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      presc      <= '0;
      load_error <= 1'b0;
    end else begin
      state      <= state_next;
      presc      <= presc_next;
      load_error <= load_error_next;
    end
  end

  always_comb begin
    state_next      = state;
    presc_next      = presc;
    load            = 1'b0;
    load_value      = 16'h0000;
    load_error_next = 1'b0;
    if (stop) begin
      state_next = IDLE;
      presc_next = '0;
      load       = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (!pause && start) begin
            if (preset_valid(preset)) begin
              state_next = RUNNING;
              presc_next = '0;
              load       = 1'b1;
              load_value = preset;
            end else begin
              load_error_next = 1'b1;
            end
          end
        end
        RUNNING: begin
          if (pause) begin
            state_next = PAUSED;
          end else if (tick) begin
            presc_next = '0;
            // 00:01 is the last value before zero; the min-tens borrow is a backstop.
            if (digits == 16'h0001 || mt_borrow) state_next = DONE;
          end else begin
            presc_next = presc + PW'(1);
          end
        end
        PAUSED: begin
          if (!pause && start) state_next = RUNNING;
        end
        DONE: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  bcd_digit_down #(.MAX(SEC_UNITS_MAX)) u_sec_units (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_value (load_value[3:0]),
    .enable     (tick),
    .borrow_in  (1'b1),
    .value      (digits[3:0]),
    .borrow_out (su_borrow)
  );

  bcd_digit_down #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_value (load_value[7:4]),
    .enable     (tick),
    .borrow_in  (su_borrow),
    .value      (digits[7:4]),
    .borrow_out (st_borrow)
  );

  bcd_digit_down #(.MAX(MIN_UNITS_MAX)) u_min_units (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_value (load_value[11:8]),
    .enable     (tick),
    .borrow_in  (st_borrow),
    .value      (digits[11:8]),
    .borrow_out (mu_borrow)
  );

  bcd_digit_down #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_value (load_value[15:12]),
    .enable     (tick),
    .borrow_in  (mu_borrow),
    .value      (digits[15:12]),
    .borrow_out (mt_borrow)
  );

  assign running  = (state == RUNNING);
  assign paused   = (state == PAUSED);
  assign valve_on = (state == RUNNING);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_irrigation_timer_sequencer.sv
// tb/tb_irrigation_timer_sequencer.sv - directed and random checks against a seconds-based model
module tb_irrigation_timer_sequencer;

  localparam int P = 4;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        stop  = 1'b0;
  logic [15:0] preset = 16'h0000;
  logic [15:0] digits;
  logic        running, paused, valve_on, done, load_error;

  int compared   = 0;
  int mismatched = 0;

  // Reference: remaining time as plain seconds plus cycles elapsed in the current second.
  int m_mode  = M_IDLE;
  int m_secs  = 0;
  int m_phase = 0;
  bit m_lerr  = 1'b0;

  irrigation_timer_sequencer #(.PRESCALE(P)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .pause      (pause),
    .stop       (stop),
    .preset     (preset),
    .digits     (digits),
    .running    (running),
    .paused     (paused),
    .valve_on   (valve_on),
    .done       (done),
    .load_error (load_error)
  );

  always #5 clock = ~clock;

  function automatic bit m_valid(input logic [15:0] p);
    return (p[15:12] <= 9) && (p[11:8] <= 9) && (p[7:4] <= 5) && (p[3:0] <= 9) && (p != 0);
  endfunction

  function automatic int bcd_to_secs(input logic [15:0] p);
    return int'(p[15:12]) * 600 + int'(p[11:8]) * 60 + int'(p[7:4]) * 10 + int'(p[3:0]);
  endfunction

  function automatic logic [15:0] secs_to_bcd(input int s);
    int m, x;
    m = s / 60;
    x = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    m_lerr = 1'b0;
    if (reset || stop) begin
      m_mode  = M_IDLE;
      m_secs  = 0;
      m_phase = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (!pause && start) begin
            if (m_valid(preset)) begin
              m_mode  = M_RUN;
              m_secs  = bcd_to_secs(preset);
              m_phase = 0;
            end else begin
              m_lerr = 1'b1;
            end
          end
        end
        M_RUN: begin
          if (pause) begin
            m_mode = M_PAUSE;
          end else if (m_phase == P - 1) begin
            m_phase = 0;
            m_secs  = m_secs - 1;
            if (m_secs == 0) m_mode = M_DONE;
          end else begin
            m_phase = m_phase + 1;
          end
        end
        M_PAUSE: if (!pause && start) m_mode = M_RUN;
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  // One clock with the current inputs, then compare every output against the model.
  task automatic cyc();
    @(posedge clock);
    #1;
    model_step();
    check("digits", digits, secs_to_bcd(m_secs));
    check("running", 16'(running), 16'(m_mode == M_RUN));
    check("paused", 16'(paused), 16'(m_mode == M_PAUSE));
    check("valve_on", 16'(valve_on), 16'(m_mode == M_RUN));
    check("done", 16'(done), 16'(m_mode == M_DONE));
    check("load_error", 16'(load_error), 16'(m_lerr));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    logic [15:0] bad [3];
    int done_seen;
    int r;

    bad[0] = 16'h0070;
    bad[1] = 16'h00A0;
    bad[2] = 16'h0000;

    #2;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("reset_digits", digits, 16'h0000);
    check("reset_flags", {11'b0, running, paused, valve_on, done, load_error}, 16'h0000);

    // Basic countdown from 00:03
    preset = 16'h0003;
    start  = 1'b1;
    cyc();
    start = 1'b0;
    check("t1_load", digits, 16'h0003);
    check("t1_running", 16'(running), 16'h0001);
    run(4);
    check("t1_0002", digits, 16'h0002);
    run(4);
    check("t1_0001", digits, 16'h0001);
    run(4);
    check("t1_zero", digits, 16'h0000);
    check("t1_done", 16'(done), 16'h0001);
    cyc();
    check("t1_idle_valve", 16'(valve_on), 16'h0000);
    check("t1_done_gone", 16'(done), 16'h0000);

    // Borrow chain across minutes
    preset = 16'h1000;
    start  = 1'b1;
    cyc();
    start = 1'b0;
    run(4);
    check("t2_0959", digits, 16'h0959);
    run(60 * P);
    check("t2_0859", digits, 16'h0859);
    stop = 1'b1;
    cyc();
    stop = 1'b0;

    // Pause on the tick cycle, then resume from the held prescaler
    preset = 16'h0005;
    start  = 1'b1;
    cyc();
    start = 1'b0;
    run(3);
    pause = 1'b1;
    run(21);
    check("t3_held", digits, 16'h0005);
    check("t3_paused", 16'(paused), 16'h0001);
    pause = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("t3_resumed_same", digits, 16'h0005);
    cyc();
    check("t3_0004", digits, 16'h0004);
    stop = 1'b1;
    cyc();
    stop = 1'b0;

    // Rejected presets
    done_seen = 0;
    for (int k = 0; k < 3; k++) begin
      preset = bad[k];
      start  = 1'b1;
      cyc();
      start = 1'b0;
      check("t4_load_error", 16'(load_error), 16'h0001);
      check("t4_digits", digits, 16'h0000);
      check("t4_running", 16'(running), 16'h0000);
      done_seen += int'(done);
      cyc();
      done_seen += int'(done);
    end
    check("t4_no_done", 16'(done_seen), 16'h0000);

    // stop outranks pause and start
    preset = 16'h0130;
    start  = 1'b1;
    cyc();
    start = 1'b0;
    run(6);
    stop  = 1'b1;
    pause = 1'b1;
    start = 1'b1;
    cyc();
    stop  = 1'b0;
    pause = 1'b0;
    start = 1'b0;
    check("t5_digits", digits, 16'h0000);
    check("t5_flags", {11'b0, running, paused, valve_on, done, load_error}, 16'h0000);

    // Reset mid-run, then a fresh one-second run
    preset = 16'h0042;
    start  = 1'b1;
    cyc();
    start = 1'b0;
    run(5);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("t6_digits", digits, 16'h0000);
    check("t6_flags", {11'b0, running, paused, valve_on, done, load_error}, 16'h0000);
    preset = 16'h0001;
    start  = 1'b1;
    cyc();
    start = 1'b0;
    run(4);
    check("t6_done", 16'(done), 16'h0001);
    check("t6_zero", digits, 16'h0000);

    // Random control traffic against the model
    for (int n = 0; n < 1500; n++) begin
      r     = int'($urandom_range(0, 999));
      reset = (r < 4);
      stop  = ($urandom_range(0, 99) < 3);
      pause = ($urandom_range(0, 99) < 10);
      start = ($urandom_range(0, 99) < 20);
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 1) preset = secs_to_bcd(int'($urandom_range(1, 40)));
        else preset = 16'($urandom);
      end
      cyc();
    end
    reset = 1'b0;
    stop  = 1'b0;
    pause = 1'b0;
    start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
